// File: rtl/control_sequencer_if.sv
// Bus between the control sequencer and its datapath/memory environment.
// The sequencer owns the master side; the datapath side uses slave.
interface control_sequencer_if;
   logic        run;
   logic        mem_rdy;
   logic [31:0] ir;

   logic        PCout;
   logic        incPC;
   logic        MARin;
   logic        read;
   logic        MDRin;
   logic        MDRout;
   logic        IRin;
   logic        Yin;
   logic        Zin;
   logic        ZLowOut;
   logic        ZHighOut;
   logic        HIin;
   logic        LOin;
   logic [15:0] Rin;
   logic [15:0] Rout;
   logic [4:0]  opcode;
   logic        busy;
   logic        done;
   logic        halted;
   logic        illegal;
   logic [15:0] instr_count;

   modport master (
      input  run, mem_rdy, ir,
      output PCout, incPC, MARin, read, MDRin, MDRout, IRin, Yin, Zin, ZLowOut, ZHighOut,
             HIin, LOin, Rin, Rout, opcode, busy, done, halted, illegal, instr_count
   );

   modport slave (
      output run, mem_rdy, ir,
      input  PCout, incPC, MARin, read, MDRin, MDRout, IRin, Yin, Zin, ZLowOut, ZHighOut,
             HIin, LOin, Rin, Rout, opcode, busy, done, halted, illegal, instr_count
   );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired fetch/decode/execute control unit: one state register, strobes decoded
// from the state and the instruction register, plus a retired-instruction counter.
module control_sequencer (
   input  logic                clock,
   input  logic                clear,
   control_sequencer_if.master bus
);

   typedef enum logic [3:0] {
      StIdle, StT0, StT1, StT2, StT3, StT4, StT5, StT6, StHalt
   } state_e;

   localparam logic [4:0] OpNop  = 5'b11010;
   localparam logic [4:0] OpHalt = 5'b11011;

   state_e      state_q, state_d;
   logic [15:0] instr_count_q, instr_count_d;

   logic [4:0]  op;
   logic [15:0] ra_oh, rb_oh, rc_oh;
   logic        is_alu3, is_alu2, is_muldiv, is_nop, is_halt;
   logic        unused_ir;

   logic pc_out, inc_pc, mar_in, rd, mdr_in, mdr_out, ir_in, y_in, z_in;
   logic zlow_out, zhigh_out, hi_in, lo_in, done_int, illegal_int;
   logic [15:0] rin, rout;
   logic [4:0]  opcode_int;
   state_e      after_done;

   assign op        = bus.ir[31:27];
   assign ra_oh     = 16'h0001 << bus.ir[26:23];
   assign rb_oh     = 16'h0001 << bus.ir[22:19];
   assign rc_oh     = 16'h0001 << bus.ir[18:15];
   assign unused_ir = ^bus.ir[14:0];

   assign is_alu3   = (op >= 5'b00011) && (op <= 5'b01011);
   assign is_alu2   = (op == 5'b10001) || (op == 5'b10010);
   assign is_muldiv = (op == 5'b01111) || (op == 5'b10000);
   assign is_nop    = (op == OpNop);
   assign is_halt   = (op == OpHalt);

   assign after_done = bus.run ? StT0 : StIdle;

   always_comb begin
      state_d     = state_q;
      pc_out      = 1'b0;
      inc_pc      = 1'b0;
      mar_in      = 1'b0;
      rd          = 1'b0;
      mdr_in      = 1'b0;
      mdr_out     = 1'b0;
      ir_in       = 1'b0;
      y_in        = 1'b0;
      z_in        = 1'b0;
      zlow_out    = 1'b0;
      zhigh_out   = 1'b0;
      hi_in       = 1'b0;
      lo_in       = 1'b0;
      done_int    = 1'b0;
      illegal_int = 1'b0;
      rin         = '0;
      rout        = '0;
      opcode_int  = OpNop;

      unique case (state_q)
         StIdle: begin
            if (bus.run) state_d = StT0;
         end
         StT0: begin
            pc_out  = 1'b1;
            mar_in  = 1'b1;
            inc_pc  = 1'b1;
            state_d = StT1;
         end
         StT1: begin
            rd = 1'b1;
            if (bus.mem_rdy) begin
               mdr_in  = 1'b1;
               state_d = StT2;
            end
         end
         StT2: begin
            mdr_out = 1'b1;
            ir_in   = 1'b1;
            state_d = StT3;
         end
         StT3: begin
            opcode_int = op;
            if (is_alu3) begin
               rout    = rb_oh;
               y_in    = 1'b1;
               state_d = StT4;
            end else if (is_alu2) begin
               rout    = rb_oh;
               z_in    = 1'b1;
               state_d = StT4;
            end else if (is_muldiv) begin
               rout    = ra_oh;
               y_in    = 1'b1;
               state_d = StT4;
            end else if (is_halt) begin
               state_d = StHalt;
            end else begin
               // NOP and every unassigned opcode retire here
               done_int    = 1'b1;
               illegal_int = !is_nop;
               state_d     = after_done;
            end
         end
         StT4: begin
            opcode_int = op;
            if (is_alu2) begin
               zlow_out = 1'b1;
               rin      = ra_oh;
               done_int = 1'b1;
               state_d  = after_done;
            end else begin
               rout    = is_alu3 ? rc_oh : rb_oh;
               z_in    = 1'b1;
               state_d = StT5;
            end
         end
         StT5: begin
            opcode_int = op;
            zlow_out   = 1'b1;
            if (is_alu3) begin
               rin      = ra_oh;
               done_int = 1'b1;
               state_d  = after_done;
            end else begin
               lo_in   = 1'b1;
               state_d = StT6;
            end
         end
         StT6: begin
            opcode_int = op;
            zhigh_out  = 1'b1;
            hi_in      = 1'b1;
            done_int   = 1'b1;
            state_d    = after_done;
         end
         StHalt: begin
            state_d = StHalt;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   assign instr_count_d = instr_count_q + {15'd0, done_int};

   always_ff @(posedge clock) begin
      if (!clear) begin
         state_q       <= StIdle;
         instr_count_q <= '0;
      end else begin
         state_q       <= state_d;
         instr_count_q <= instr_count_d;
      end
   end

   // Everything visible is forced quiet while clear is held low
   assign bus.PCout       = clear & pc_out;
   assign bus.incPC       = clear & inc_pc;
   assign bus.MARin       = clear & mar_in;
   assign bus.read        = clear & rd;
   assign bus.MDRin       = clear & mdr_in;
   assign bus.MDRout      = clear & mdr_out;
   assign bus.IRin        = clear & ir_in;
   assign bus.Yin         = clear & y_in;
   assign bus.Zin         = clear & z_in;
   assign bus.ZLowOut     = clear & zlow_out;
   assign bus.ZHighOut    = clear & zhigh_out;
   assign bus.HIin        = clear & hi_in;
   assign bus.LOin        = clear & lo_in;
   assign bus.Rin         = clear ? rin : 16'h0000;
   assign bus.Rout        = clear ? rout : 16'h0000;
   assign bus.opcode      = clear ? opcode_int : OpNop;
   assign bus.done        = clear & done_int;
   assign bus.illegal     = clear & illegal_int;
   assign bus.halted      = clear & (state_q == StHalt);
   assign bus.busy        = clear & (state_q != StIdle) & (state_q != StHalt);
   assign bus.instr_count = instr_count_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench: stimulus pushes expected per-cycle outputs, a monitor pops and
// compares one record on every busy cycle.
module tb_control_sequencer;

   typedef struct packed {
      logic        pc_out, inc_pc, mar_in, read, mdr_in, mdr_out, ir_in;
      logic        y_in, z_in, zlow_out, zhigh_out, hi_in, lo_in;
      logic [15:0] rin, rout;
      logic [4:0]  opc;
      logic        busy, done, halted, illegal;
      logic [15:0] cnt;
   } rec_t;

   logic clock = 1'b0;
   logic clear = 1'b0;

   control_sequencer_if bus ();

   control_sequencer dut (
      .clock (clock),
      .clear (clear),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   rec_t        exp_q[$];
   string       tag_q[$];
   int          checks = 0;
   int          errors = 0;
   logic [15:0] exp_cnt = 16'h0000;

   function automatic rec_t blank();
      rec_t r;
      r      = '0;
      r.opc  = 5'b11010;
      r.busy = 1'b1;
      r.cnt  = exp_cnt;
      return r;
   endfunction

   function automatic rec_t sample();
      rec_t r;
      r.pc_out    = bus.PCout;
      r.inc_pc    = bus.incPC;
      r.mar_in    = bus.MARin;
      r.read      = bus.read;
      r.mdr_in    = bus.MDRin;
      r.mdr_out   = bus.MDRout;
      r.ir_in     = bus.IRin;
      r.y_in      = bus.Yin;
      r.z_in      = bus.Zin;
      r.zlow_out  = bus.ZLowOut;
      r.zhigh_out = bus.ZHighOut;
      r.hi_in     = bus.HIin;
      r.lo_in     = bus.LOin;
      r.rin       = bus.Rin;
      r.rout      = bus.Rout;
      r.opc       = bus.opcode;
      r.busy      = bus.busy;
      r.done      = bus.done;
      r.halted    = bus.halted;
      r.illegal   = bus.illegal;
      r.cnt       = bus.instr_count;
      return r;
   endfunction

   // Monitor
   always @(negedge clock) begin
      if (clear && bus.busy) begin
         rec_t act, exp;
         string tag;
         act = sample();
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_busy got %h want no busy cycle", act);
         end else begin
            exp = exp_q.pop_front();
            tag = tag_q.pop_front();
            if (act !== exp) begin
               errors++;
               $display("FAIL %s got %h want %h", tag, act, exp);
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %h want %h", name, got, want);
      end
   endtask

   task automatic push(input rec_t r, input string t);
      exp_q.push_back(r);
      tag_q.push_back(t);
   endtask

   task automatic push_fetch(input int waits, input string t);
      rec_t r;
      r = blank(); r.pc_out = 1; r.inc_pc = 1; r.mar_in = 1; push(r, {t, "_t0"});
      for (int i = 0; i < waits; i++) begin
         r = blank(); r.read = 1; push(r, {t, "_t1wait"});
      end
      r = blank(); r.read = 1; r.mdr_in = 1; push(r, {t, "_t1"});
      r = blank(); r.mdr_out = 1; r.ir_in = 1; push(r, {t, "_t2"});
   endtask

   task automatic push_alu3(input logic [4:0] op, input logic [15:0] rout3,
                            input logic [15:0] rout4, input logic [15:0] rin5, input string t);
      rec_t r;
      r = blank(); r.opc = op; r.rout = rout3; r.y_in = 1; push(r, {t, "_t3"});
      r = blank(); r.opc = op; r.rout = rout4; r.z_in = 1; push(r, {t, "_t4"});
      r = blank(); r.opc = op; r.rin = rin5; r.zlow_out = 1; r.done = 1; push(r, {t, "_t5"});
      exp_cnt++;
   endtask

   task automatic push_alu2(input logic [4:0] op, input logic [15:0] rout3,
                            input logic [15:0] rin4, input string t);
      rec_t r;
      r = blank(); r.opc = op; r.rout = rout3; r.z_in = 1; push(r, {t, "_t3"});
      r = blank(); r.opc = op; r.rin = rin4; r.zlow_out = 1; r.done = 1; push(r, {t, "_t4"});
      exp_cnt++;
   endtask

   task automatic push_muldiv(input logic [4:0] op, input logic [15:0] rout3,
                              input logic [15:0] rout4, input string t);
      rec_t r;
      r = blank(); r.opc = op; r.rout = rout3; r.y_in = 1; push(r, {t, "_t3"});
      r = blank(); r.opc = op; r.rout = rout4; r.z_in = 1; push(r, {t, "_t4"});
      r = blank(); r.opc = op; r.zlow_out = 1; r.lo_in = 1; push(r, {t, "_t5"});
      r = blank(); r.opc = op; r.zhigh_out = 1; r.hi_in = 1; r.done = 1; push(r, {t, "_t6"});
      exp_cnt++;
   endtask

   task automatic push_t3(input logic [4:0] op, input logic dn, input logic ill, input string t);
      rec_t r;
      r = blank(); r.opc = op; r.done = dn; r.illegal = ill; push(r, {t, "_t3"});
      if (dn) exp_cnt++;
   endtask

   // Returns at the rising edge that follows the last expected busy cycle
   task automatic drive_instr(input logic [31:0] ir, input int waits, input bit keep_run);
      int n;
      #1;
      bus.ir      = ir;
      bus.run     = 1'b1;
      bus.mem_rdy = (waits == 0);
      @(posedge clock); #1;
      if (!keep_run) bus.run = 1'b0;
      if (waits > 0) begin
         repeat (waits + 1) @(posedge clock);
         #1 bus.mem_rdy = 1'b1;
      end
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(posedge clock);
         n++;
      end
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL timeout got %0d pending records want 0", exp_q.size());
         exp_q.delete();
         tag_q.delete();
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got no finish want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rec_t r;
      bus.run = 1'b0; bus.mem_rdy = 1'b1; bus.ir = 32'h0;

      // Combinational quiet while clear is low
      #1;
      check("clear_strobes", 32'({bus.PCout, bus.MARin, bus.read, bus.done, bus.halted}), 32'd0);
      check("clear_opcode", 32'(bus.opcode), 32'h1A);
      repeat (2) @(posedge clock);
      #1 clear = 1'b1;
      #1;
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_count", 32'(bus.instr_count), 32'd0);
      check("rst_rin_rout", {bus.Rin, bus.Rout}, 32'd0);
      check("rst_opcode", 32'(bus.opcode), 32'h1A);

      // ADD r4 <- r3 + r7
      push_fetch(0, "add");
      push_alu3(5'b00011, 16'h0008, 16'h0080, 16'h0010, "add");
      drive_instr(32'h1A1B8000, 0, 0);
      #1 check("add_count", 32'(bus.instr_count), 32'd1);
      check("add_idle", 32'(bus.busy), 32'd0);

      // NEG r5 <- -r0
      push_fetch(0, "neg");
      push_alu2(5'b10001, 16'h0001, 16'h0020, "neg");
      drive_instr(32'h8A800000, 0, 0);

      // MUL r2, r6
      push_fetch(0, "mul");
      push_muldiv(5'b01111, 16'h0004, 16'h0040, "mul");
      drive_instr(32'h79300000, 0, 0);

      // DIV r1, r15
      push_fetch(0, "div");
      push_muldiv(5'b10000, 16'h0002, 16'h8000, "div");
      drive_instr(32'h80F80000, 0, 0);

      // NOP with three wait cycles in T1
      push_fetch(3, "wait");
      push_t3(5'b11010, 1'b1, 1'b0, "wait");
      drive_instr(32'hD0000000, 3, 0);

      // Back-to-back NOPs with run held
      push_fetch(0, "b2b1");
      push_t3(5'b11010, 1'b1, 1'b0, "b2b1");
      drive_instr(32'hD0000000, 0, 1);
      push_fetch(0, "b2b2");
      push_t3(5'b11010, 1'b1, 1'b0, "b2b2");
      drive_instr(32'hD0000000, 0, 0);
      #1 check("b2b_count", 32'(bus.instr_count), 32'd7);

      // Illegal opcode 11111
      push_fetch(0, "ill");
      push_t3(5'b11111, 1'b1, 1'b1, "ill");
      drive_instr(32'hF8000000, 0, 0);
      #1 check("ill_count", 32'(bus.instr_count), 32'd8);

      // HALT then hold run high
      push_fetch(0, "halt");
      push_t3(5'b11011, 1'b0, 1'b0, "halt");
      drive_instr(32'hD8000000, 0, 1);
      for (int i = 0; i < 3; i++) begin
         #1 check("halt_hold", 32'({bus.halted, bus.busy}), 32'b10);
         @(posedge clock);
      end
      #1 clear = 1'b0; bus.run = 1'b0;
      #1 check("halt_clear_comb", 32'(bus.halted), 32'd0);
      @(posedge clock);
      #1 clear = 1'b1;
      #1 check("halt_reset", 32'({bus.halted, bus.busy}), 32'd0);
      check("halt_reset_count", 32'(bus.instr_count), 32'd0);
      exp_cnt = 16'h0000;

      // Reset during T4 of ADD
      push_fetch(0, "radd");
      r = blank(); r.opc = 5'b00011; r.rout = 16'h0008; r.y_in = 1; push(r, "radd_t3");
      drive_instr(32'h1A1B8000, 0, 0);
      #1 clear = 1'b0;
      #1 check("radd_t4_quiet", 32'({bus.Zin, bus.done, bus.ZLowOut}), 32'd0);
      check("radd_t4_rout", 32'(bus.Rout), 32'd0);
      @(posedge clock);
      #1 clear = 1'b1;
      #1 check("radd_idle", 32'(bus.busy), 32'd0);
      check("radd_count", 32'(bus.instr_count), 32'd0);
      check("radd_opcode", 32'(bus.opcode), 32'h1A);
      @(posedge clock);
      #1 check("radd_no_rin", {bus.Rin, 15'd0, bus.busy}, 32'd0);

      // Counter wrap: preload near wrap, then one NOP
      force dut.instr_count_q = 16'hFFFF;
      @(posedge clock);
      #1 release dut.instr_count_q;
      #1 check("wrap_preload", 32'(bus.instr_count), 32'hFFFF);
      exp_cnt = 16'hFFFF;
      push_fetch(0, "wrap");
      push_t3(5'b11010, 1'b1, 1'b0, "wrap");
      drive_instr(32'hD0000000, 0, 0);
      #1 check("wrap_count", 32'(bus.instr_count), 32'd0);

      repeat (2) @(posedge clock);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset, ports listed below with the clock and reset first.
- clock  in  1  rising-edge clock
- clear  in  1  synchronous active-low reset
- run  in  1  permit to start/continue fetching
- mem_rdy  in  1  memory read complete
- ir  in  32  IR contents; [31:27] opcode, [26:23] Ra, [22:19] Rb, [18:15] Rc
- PCout, incPC, MARin, read, MDRin, MDRout, IRin, Yin, Zin, ZLowOut, ZHighOut, HIin, LOin  out  1 each  datapath strobes
- Rin, Rout  out  16 each  register-file enables, bit n = Rn
- opcode  out  5  ALU operation select
- busy, done, halted, illegal  out  1 each  status
- instr_count  out  16  retired-instruction counter

Function
REQ-002 States SHALL be IDLE, T0, T1, T2, T3, T4, T5, T6 and HALT, held in a single state register.
REQ-003 Strobes SHALL be decoded from the state register and ir only; every strobe not listed for a state SHALL be 0.
REQ-004 IDLE SHALL go to T0 when run=1 and otherwise stay in IDLE.
REQ-005 T0 SHALL assert PCout, MARin and incPC, then go to T1.
REQ-006 T1 SHALL assert read and stay in T1 while mem_rdy=0.
REQ-007 In T1 with mem_rdy=1, MDRin SHALL be asserted and the next state SHALL be T2.
REQ-008 T2 SHALL assert MDRout and IRin, then go to T3; ir SHALL be decoded from T3 onward.
REQ-009 ALU3 class (opcodes 00011-01011):
- T3: Rout[Rb] and Yin.
- T4: Rout[Rc] and Zin.
- T5: ZLowOut, Rin[Ra] and done.
REQ-010 ALU2 class (10001 neg, 10010 not):
- T3: Rout[Rb] and Zin.
- T4: ZLowOut, Rin[Ra] and done.
REQ-011 MULDIV class (01111 mul, 10000 div):
- T3: Rout[Ra] and Yin.
- T4: Rout[Rb] and Zin.
- T5: ZLowOut and LOin.
- T6: ZHighOut, HIin and done.
REQ-012 NOP (11010) SHALL assert done in T3 with no strobes.
REQ-013 Every other opcode except HALT SHALL assert done and illegal for one cycle in T3, with no strobes.
REQ-014 HALT (11011) in T3 SHALL go to HALT.
REQ-015 HALT SHALL hold halted=1 and ignore run until clear=0.
REQ-016 After the done state, the next state SHALL be T0 if run=1, else IDLE.
REQ-017 A run deassertion mid-instruction SHALL NOT abort the instruction.
REQ-018 opcode SHALL equal ir[31:27] in T3-T6 and 5'b11010 in all other states.
REQ-019 Rin and Rout SHALL each be one-hot or zero.
REQ-020 busy SHALL be 1 in T0-T6 and 0 in IDLE and HALT.
REQ-021 done SHALL be a single-cycle pulse per instruction.
REQ-022 instr_count SHALL increment on each cycle with done=1 and wrap from 16'hFFFF to 0.
REQ-023 Latency SHALL be, in cycles excluding memory wait:
- NOP or illegal: 4.
- ALU2: 5.
- ALU3: 6.
- MULDIV: 7.

Reset
REQ-024 clear=0 at a rising edge SHALL force the state to IDLE and instr_count to 0 from any state, including mid-T1 wait and HALT.
REQ-025 All strobes, done, illegal and halted SHALL be 0 combinationally while clear=0.
REQ-026 After reset, opcode SHALL be 5'b11010, and Rin and Rout SHALL be 0.

Verification
REQ-027 ADD: run=1, mem_rdy=1, ir=32'h1A1B8000 -> Rout=16'h0008 with Yin in T3; Rout=16'h0080 with Zin and opcode=00011 in T4; Rin=16'h0010 with ZLowOut and done in T5; instr_count=1.
REQ-028 NEG: ir=32'h8A800000 -> Rout=16'h0001 with Zin and opcode=10001 in T3; Rin=16'h0020 with ZLowOut and done in T4.
REQ-029 MUL: ir=32'h79300000 -> Rout=16'h0004 in T3; Rout=16'h0040 in T4; LOin in T5; HIin, ZHighOut and done in T6; no Rin bits set.
REQ-030 Memory wait: mem_rdy=0 for 3 cycles in T1 -> read high for 4 cycles, MDRin only in the last, IRin in the following cycle.
REQ-031 Illegal and HALT: ir opcode 11111 -> illegal and done pulse, instr_count increments; then opcode 11011 -> halted=1 and busy=0, staying halted with run=1 until clear=0.
REQ-032 Reset mid-instruction and wrap:
- clear=0 during T4 of ADD -> IDLE next cycle, strobes 0, instr_count=0, no Rin pulse.
- instr_count preloaded via 65535 NOPs -> wraps to 0 on the next done.
